// File: rtl/cache_exerciser.sv
// Write/verify traffic generator for the 32-bit cache front-end port.
// Optional watchdog on stalled accesses: define CACHE_EXERCISER_TIMEOUT_EN.
module cache_exerciser #(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned WORD_COUNT   = 256,
    parameter int unsigned STRIDE_BYTES = 4,
    parameter logic [31:0] PATTERN_SEED = 32'hA5C3_0F1E,
    parameter int unsigned PASSES       = 2,
    parameter bit          BYTE_WRITES  = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        mem_busy,
    output logic [31:0] cache_address,
    output logic [31:0] cache_data_in,
    output logic [3:0]  cache_write_enable,
    input  logic [31:0] cache_data_out,
    input  logic        cache_data_out_ready,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [31:0] first_fail_addr
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_WR_ISSUE, S_WR_WAIT, S_RD_ISSUE, S_RD_WAIT, S_DONE
    } state_t;

    localparam logic [15:0] LAST_WORD = 16'(WORD_COUNT - 1);
    localparam logic [3:0]  LAST_PASS = 4'(PASSES - 1);
    localparam logic [31:0] STRIDE    = 32'(STRIDE_BYTES);

    state_t      state_q, state_d;
    logic [15:0] word_q, word_d;
    logic [3:0]  pidx_q, pidx_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] cur_addr_q, cur_addr_d;
    logic [31:0] addr_out_q, addr_out_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  we_q, we_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [15:0] err_q, err_d;
    logic [31:0] ffa_q, ffa_d;
`ifdef CACHE_EXERCISER_TIMEOUT_EN
    logic [15:0] wdog_q, wdog_d;
`endif

    // Odd passes write the complement so stale data from the previous pass cannot match.
    logic [31:0] pattern;
    assign pattern = pidx_q[0] ? ~(cur_addr_q ^ PATTERN_SEED) : (cur_addr_q ^ PATTERN_SEED);

    logic [15:0] err_inc;
    assign err_inc = (err_q == 16'hFFFF) ? err_q : err_q + 16'd1;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        word_d     = word_q;
        pidx_d     = pidx_q;
        byte_d     = byte_q;
        cur_addr_d = cur_addr_q;
        addr_out_d = addr_out_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        ffa_d      = ffa_q;
        case (state_q)
            S_IDLE: if (start) begin
                done_d     = 1'b0;
                pass_d     = 1'b0;
                err_d      = '0;
                ffa_d      = '0;
                busy_d     = 1'b1;
                word_d     = '0;
                pidx_d     = '0;
                byte_d     = '0;
                cur_addr_d = ADDR_BASE;
                state_d    = S_WAIT_INIT;
            end
            S_WAIT_INIT: if (!mem_busy) state_d = S_WR_ISSUE;
            S_WR_ISSUE: begin
                addr_out_d = cur_addr_q;
                wdata_d    = pattern;
                we_d       = BYTE_WRITES ? (4'b0001 << byte_q) : 4'b1111;
                state_d    = S_WR_WAIT;
            end
            S_WR_WAIT: if (cache_data_out_ready) begin
                we_d = '0;
                if (BYTE_WRITES && byte_q != 2'd3) begin
                    byte_d  = byte_q + 2'd1;
                    state_d = S_WR_ISSUE;
                end else begin
                    byte_d = '0;
                    if (word_q != LAST_WORD) begin
                        word_d     = word_q + 16'd1;
                        cur_addr_d = cur_addr_q + STRIDE;
                        state_d    = S_WR_ISSUE;
                    end else begin
                        word_d     = '0;
                        cur_addr_d = ADDR_BASE;
                        state_d    = S_RD_ISSUE;
                    end
                end
            end
            S_RD_ISSUE: begin
                addr_out_d = cur_addr_q;
                we_d       = '0;
                state_d    = S_RD_WAIT;
            end
            S_RD_WAIT: if (cache_data_out_ready) begin
                if (cache_data_out != pattern) begin
                    err_d = err_inc;
                    if (err_q == 16'd0) ffa_d = cur_addr_q;
                end
                if (word_q != LAST_WORD) begin
                    word_d     = word_q + 16'd1;
                    cur_addr_d = cur_addr_q + STRIDE;
                    state_d    = S_RD_ISSUE;
                end else if (pidx_q != LAST_PASS) begin
                    pidx_d     = pidx_q + 4'd1;
                    word_d     = '0;
                    cur_addr_d = ADDR_BASE;
                    state_d    = S_WR_ISSUE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                pass_d  = (err_q == 16'd0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
`ifdef CACHE_EXERCISER_TIMEOUT_EN
        wdog_d = '0;
        if ((state_q == S_WR_WAIT || state_q == S_RD_WAIT) && !cache_data_out_ready) begin
            if (wdog_q == 16'hFFFF) begin
                we_d    = '0;
                err_d   = 16'hFFFF;
                ffa_d   = cur_addr_q;
                state_d = S_DONE;
            end else begin
                wdog_d = wdog_q + 16'd1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            word_q     <= '0;
            pidx_q     <= '0;
            byte_q     <= '0;
            cur_addr_q <= ADDR_BASE;
            addr_out_q <= '0;
            wdata_q    <= '0;
            we_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_q      <= '0;
            ffa_q      <= '0;
`ifdef CACHE_EXERCISER_TIMEOUT_EN
            wdog_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_q     <= word_d;
            pidx_q     <= pidx_d;
            byte_q     <= byte_d;
            cur_addr_q <= cur_addr_d;
            addr_out_q <= addr_out_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_q      <= err_d;
            ffa_q      <= ffa_d;
`ifdef CACHE_EXERCISER_TIMEOUT_EN
            wdog_q     <= wdog_d;
`endif
        end
    end

    assign cache_address      = addr_out_q;
    assign cache_data_in      = wdata_q;
    assign cache_write_enable = we_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign pass               = pass_q;
    assign err_count          = err_q;
    assign first_fail_addr    = ffa_q;

endmodule

// File: doc/cache_exerciser.md
Name: cache_exerciser

Overview:
Self-checking traffic generator that drives the 32-bit cache front-end port (address / data_in / write_enable / data_out / data_out_ready).
- Write pass: fills a word range with a deterministic pattern.
- Read pass: reads the range back, compares each word and reports pass/fail, error count and first failing address.
- Replaces the fixed read/write ping-pong used for board bring-up. Sits at top level between start/status pins and the cache.
- Parametrised in range, stride, pass count and write granularity.

Parameters:
ADDR_BASE, 32'h0000_0000, byte address of first word; must be 4-byte aligned.
WORD_COUNT, 256, number of 32-bit words per pass; range 1..65535.
STRIDE_BYTES, 4, address increment per word; multiple of 4, at least 4.
PATTERN_SEED, 32'hA5C3_0F1E, XOR seed for the data pattern.
PASSES, 2, number of write+verify rounds; range 1..15.
BYTE_WRITES, 0, 0 = one 4'b1111 write per word; 1 = four single-byte writes per word.

Ports:
sys_clk  in  1  system clock (27 MHz)
sys_rst_n  in  1  asynchronous active-low reset
start  in  1  level; sampled in IDLE, a 1 starts a run
mem_busy  in  1  backing burst RAM still initialising; no access is issued while high
cache_address  out  32  byte address to cache
cache_data_in  out  32  write data to cache
cache_write_enable  out  4  byte write strobes; 0 = read
cache_data_out  in  32  read data from cache
cache_data_out_ready  in  1  access at current address complete (read data valid / write committed)
busy  out  1  run in progress
done  out  1  run finished; held until next start
pass  out  1  valid when done: 1 = zero mismatches
err_count  out  16  mismatching words; saturates at 16'hFFFF
first_fail_addr  out  32  address of first mismatch; 0 if none

Behaviour:
- Reset (async, sys_rst_n low): state IDLE; all outputs 0, including cache_write_enable = 0 immediately. Internal word index, pass index and byte index all cleared.
- Pattern for word i in pass p:
  - a = ADDR_BASE + i*STRIDE_BYTES (32-bit, wraps modulo 2^32; no error is raised).
  - d = a ^ PATTERN_SEED when p is even; ~(a ^ PATTERN_SEED) when p is odd.
- Handshake:
  - Exerciser drives address, data and strobes, then holds them unchanged until it samples cache_data_out_ready = 1.
  - In the cycle after that sample, cache_write_enable returns to 0 (ISSUE state) before the next access is presented.
  - Minimum 2 cycles per access.
- States:
  - IDLE: start=1 -> clear done, pass, err_count, first_fail_addr; busy=1; -> WAIT_INIT.
  - WAIT_INIT: stay while mem_busy=1; else -> WR_ISSUE.
  - WR_ISSUE: present a and d.
    - BYTE_WRITES=0: strobes 4'b1111.
    - BYTE_WRITES=1: strobes 4'b0001 << b, with b = 0..3.
    - -> WR_WAIT.
  - WR_WAIT: on ready -> strobes 0.
    - More bytes (BYTE_WRITES=1, b<3): b++, -> WR_ISSUE.
    - Else more words: i++, -> WR_ISSUE.
    - Else: i=0, -> RD_ISSUE.
  - RD_ISSUE: present a with strobes 0; -> RD_WAIT.
  - RD_WAIT: on ready, compare cache_data_out with d.
    - On mismatch: err_count++ (saturating). If it was 0 before, first_fail_addr <= a.
    - More words: i++, -> RD_ISSUE.
    - Else if p < PASSES-1: p++, i=0, -> WR_ISSUE.
    - Else -> DONE.
  - DONE: busy=0, done=1, pass=(err_count==0); -> IDLE. done/pass/err_count/first_fail_addr are held until the next start.
- start is ignored while busy=1.
- start held high continuously: a new run begins 1 cycle after DONE.
- cache_data_out_ready outside WR_WAIT/RD_WAIT is ignored.
- WORD_COUNT=1: single write then single read per pass.
- Reset mid-access abandons the access; no recovery handshake toward the cache.

Optional Feature:
CACHE_EXERCISER_TIMEOUT_EN
- Defined:
  - A 16-bit watchdog counts cycles spent in WR_WAIT or RD_WAIT; it clears on every ready.
  - On reaching 16'hFFFF: strobes 0, err_count forced to 16'hFFFF, first_fail_addr <= current a, -> DONE with pass=0.
- Undefined: no watchdog; the exerciser waits indefinitely for ready.

Test Plan:
1. Ideal cache model (ready 1 cycle after presentation, perfect storage), defaults, start pulse -> 2 passes x 256 writes + 256 reads; done=1, pass=1, err_count=0, first_fail_addr=0; first write a=0, d=32'hA5C3_0F1E, strobes 4'b1111.
2. Model corrupts read data at address 32'h0000_0010 and 32'h0000_0020 in pass 0 -> err_count=2, first_fail_addr=32'h0000_0010, pass=0.
3. BYTE_WRITES=1, WORD_COUNT=2, PASSES=1 -> strobe sequence 0001,0010,0100,1000 per word with 0 between accesses; 8 write handshakes, 2 reads, pass=1.
4. mem_busy held high 100 cycles after start -> cache_write_enable=0 and address unchanged throughout; first write issued 1 cycle after mem_busy falls.
5. Assert sys_rst_n=0 mid-WR_WAIT with strobes 4'b1111 -> strobes 0 and busy 0 without waiting for a clock edge; a subsequent start restarts at ADDR_BASE.
6. With CACHE_EXERCISER_TIMEOUT_EN, model never asserts ready -> after 65535 cycles: done=1, pass=0, err_count=16'hFFFF, first_fail_addr=ADDR_BASE.
